vram_dp_engine: RTL and testbench

// - Parametrised dual-port video RAM; successor to the single-port BLOCK/LUTRAM wrapper.
// - Port A: read/write pixel path for drawing logic, with per-colour-channel write mask.
// - Port B: read-only scanout path for the VGA timing generator, with valid tracking.
// - Built-in clear engine fills memory with a constant after reset or on request.

---
 rtl/vram_pkg.sv | 19 +
 rtl/vram_rd_pipe.sv | 42 ++++
 rtl/vram_dp_engine.sv | 165 ++++++++++++++++
 tb/tb_vram_dp_engine.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_pkg.sv
// Shared types and constants for the dual-port video RAM engine.
package vram_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_RUN  = 1'b1
  } clr_state_t;

  localparam string STYLE_BLOCK = "BLOCK";
  localparam string STYLE_DIST  = "distributed";
  localparam string A_MODE_RF   = "READ_FIRST";
  localparam string A_MODE_WF   = "WRITE_FIRST";

  // Width of one colour lane inside a pixel word.
  function automatic int laneWidth(input int dwidth, input int channels);
    return dwidth / channels;
  endfunction

endpackage

// File: rtl/vram_rd_pipe.sv
// Read-result delay line: RD_LAT stages of data plus a matching valid bit.
// Data stages only load behind a valid, so the output holds between reads.
module vram_rd_pipe #(
  parameter int DWIDTH = 12,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vld_i,
  input  logic [DWIDTH-1:0] data_i,
  output logic              vld_o,
  output logic [DWIDTH-1:0] data_o
);

  logic [DWIDTH-1:0] data_q [RD_LAT];
  logic [RD_LAT-1:0] vld_q;

  // Shift valid every cycle and move data forward only where a valid is travelling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int s = 0; s < RD_LAT; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      vld_q[0] <= vld_i;
      if (vld_i) begin
        data_q[0] <= data_i;
      end
      for (int s = 1; s < RD_LAT; s++) begin
        vld_q[s] <= vld_q[s-1];
        if (vld_q[s-1]) begin
          data_q[s] <= data_q[s-1];
        end
      end
    end
  end

  assign vld_o  = vld_q[RD_LAT-1];
  assign data_o = data_q[RD_LAT-1];

endmodule

// File: rtl/vram_dp_engine.sv
// Dual-port video RAM: masked read/write pixel port A, read-only scanout
// port B, and a clear engine that fills the array one word per cycle.
module vram_dp_engine
  import vram_pkg::*;
#(
  parameter int    DWORD      = 16384,
  parameter int    DWIDTH     = 12,
  parameter int    CHANNELS   = 3,
  parameter int    AWIDTH     = $clog2(DWORD + 1),
  parameter string STYLE      = "BLOCK",
  parameter int    RD_LAT     = 1,
  parameter string A_MODE     = "READ_FIRST",
  parameter bit    CLR_ON_RST = 1'b1,
  parameter string INITFILE   = ""
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_req,
  input  logic [DWIDTH-1:0]   clr_val,
  output logic                busy,
  input  logic                a_en,
  input  logic [CHANNELS-1:0] a_we,
  input  logic [AWIDTH-1:0]   a_addr,
  input  logic [DWIDTH-1:0]   a_din,
  output logic [DWIDTH-1:0]   a_dout,
  output logic                a_ready,
  input  logic                b_re,
  input  logic [AWIDTH-1:0]   b_addr,
  output logic [DWIDTH-1:0]   b_dout,
  output logic                b_valid
);

  localparam int                LANE        = laneWidth(DWIDTH, CHANNELS);
  localparam int                IDXW        = (DWORD > 1) ? $clog2(DWORD) : 1;
  localparam bit                WRITE_FIRST = (A_MODE == A_MODE_WF);
  localparam logic [AWIDTH-1:0] DWORD_A     = AWIDTH'(DWORD);
  localparam logic [AWIDTH-1:0] LAST_A      = AWIDTH'(DWORD - 1);

  if ((DWIDTH % CHANNELS) != 0) begin : gBadLanes
    $error("vram_dp_engine: DWIDTH must be a multiple of CHANNELS");
  end
  if ((RD_LAT != 1) && (RD_LAT != 2)) begin : gBadLat
    $error("vram_dp_engine: RD_LAT must be 1 or 2");
  end
  if ((STYLE != STYLE_BLOCK) && (STYLE != STYLE_DIST)) begin : gBadStyle
    $error("vram_dp_engine: STYLE must be BLOCK or distributed");
  end
  if ((A_MODE != A_MODE_RF) && (A_MODE != A_MODE_WF)) begin : gBadMode
    $error("vram_dp_engine: A_MODE must be READ_FIRST or WRITE_FIRST");
  end

  (* ram_style = STYLE *) logic [DWIDTH-1:0] mem [DWORD];

  clr_state_t        state_q, state_d;
  logic [AWIDTH-1:0] clrAddr_q, clrAddr_d;
  logic [DWIDTH-1:0] clrVal_q, clrVal_d;
  logic              clrFirst_q, clrFirst_d;
  logic [DWIDTH-1:0] clrData;

  logic              aAcc, aInRange, aWrite, bInRange;
  logic [IDXW-1:0]   aIdx, bIdx, clrIdx;
  logic [DWIDTH-1:0] aOld, aMerged, aRdData, bRdData;

  assign busy     = (state_q == CLR_RUN);
  assign a_ready  = ~busy;
  assign aAcc     = a_en & a_ready;
  assign aInRange = (a_addr < DWORD_A);
  assign bInRange = (b_addr < DWORD_A);
  assign aWrite   = aAcc & aInRange;
  assign aIdx     = a_addr[IDXW-1:0];
  assign bIdx     = b_addr[IDXW-1:0];
  assign clrIdx   = clrAddr_q[IDXW-1:0];
  // A reset-started clear has no latched fill value yet, so its first word comes straight from clr_val.
  assign clrData  = clrFirst_q ? clr_val : clrVal_q;

  // Clear FSM registers; reset either parks the engine or arms an immediate fill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= CLR_ON_RST ? CLR_RUN : CLR_IDLE;
      clrAddr_q  <= '0;
      clrVal_q   <= '0;
      clrFirst_q <= CLR_ON_RST;
    end else begin
      state_q    <= state_d;
      clrAddr_q  <= clrAddr_d;
      clrVal_q   <= clrVal_d;
      clrFirst_q <= clrFirst_d;
    end
  end

  // Clear FSM next state: start on request when idle, sweep 0..DWORD-1, then idle again.
  always_comb begin
    state_d    = state_q;
    clrAddr_d  = clrAddr_q;
    clrVal_d   = clrVal_q;
    clrFirst_d = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req) begin
          state_d   = CLR_RUN;
          clrAddr_d = '0;
          clrVal_d  = clr_val;
        end
      end
      CLR_RUN: begin
        if (clrFirst_q) begin
          clrVal_d = clr_val;
        end
        if (clrAddr_q == LAST_A) begin
          state_d   = CLR_IDLE;
          clrAddr_d = '0;
        end else begin
          clrAddr_d = clrAddr_q + AWIDTH'(1);
        end
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  // Port A read view: old word, and the lane-merged word for write-first mode.
  always_comb begin
    aOld    = aInRange ? mem[aIdx] : '0;
    aMerged = aOld;
    for (int i = 0; i < CHANNELS; i++) begin
      if (a_we[i]) begin
        aMerged[i*LANE +: LANE] = a_din[i*LANE +: LANE];
      end
    end
    aRdData = (WRITE_FIRST && aInRange) ? aMerged : aOld;
  end

  assign bRdData = bInRange ? mem[bIdx] : '0;

  // Single write port: the clear engine owns it while running, otherwise port A writes its masked lanes.
  always_ff @(posedge clk) begin
    if (state_q == CLR_RUN) begin
      mem[clrIdx] <= clrData;
    end else if (aWrite) begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (a_we[i]) begin
          mem[aIdx][i*LANE +: LANE] <= a_din[i*LANE +: LANE];
        end
      end
    end
  end

  vram_rd_pipe #(.DWIDTH(DWIDTH), .RD_LAT(RD_LAT)) uPipeA (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (aAcc),
    .data_i (aRdData),
    .vld_o  (),
    .data_o (a_dout)
  );

  vram_rd_pipe #(.DWIDTH(DWIDTH), .RD_LAT(RD_LAT)) uPipeB (
    .clk    (clk),
    .rst_n  (rst_n),
    .vld_i  (b_re),
    .data_i (bRdData),
    .vld_o  (b_valid),
    .data_o (b_dout)
  );

endmodule

// File: tb/tb_vram_dp_engine.sv
// Bench for vram_dp_engine: two instances (RD_LAT=1 read-first, RD_LAT=2
// write-first) share stimulus; a scoreboard queue per port and instance
// holds expected words with the cycle they are due.
`timescale 1ns/1ps
module tb_vram_dp_engine;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b1;
  logic        clr_req = 1'b0;
  logic [11:0] clr_val = 12'h000;
  logic        a_en    = 1'b0;
  logic [2:0]  a_we    = 3'b000;
  logic [4:0]  a_addr  = 5'd0;
  logic [11:0] a_din   = 12'h000;
  logic        b_re    = 1'b0;
  logic [4:0]  b_addr  = 5'd0;

  logic        busy0, busy1, aReady0, aReady1, bValid0, bValid1;
  logic [11:0] aDout0, aDout1, bDout0, bDout1;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;

  typedef struct {
    logic [11:0] data;
    int          due;
    string       tag;
  } sb_t;

  sb_t aQ0[$];
  sb_t aQ1[$];
  sb_t bQ0[$];
  sb_t bQ1[$];

  typedef struct {
    string       name;
    bit          aEn;
    logic [2:0]  we;
    logic [4:0]  aAddr;
    logic [11:0] din;
    logic [11:0] expRf;
    logic [11:0] expWf;
    bit          bRe;
    logic [4:0]  bAddr;
    logic [11:0] expB;
  } vec_t;

  vec_t vecs[13];

  always #5 clk = ~clk;

  // Free-running cycle count used to timestamp scoreboard entries.
  always @(posedge clk) cycle <= cycle + 1;

  vram_dp_engine #(
    .DWORD(16), .DWIDTH(12), .CHANNELS(3), .STYLE("BLOCK"),
    .RD_LAT(1), .A_MODE("READ_FIRST"), .CLR_ON_RST(1'b1), .INITFILE("")
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_val(clr_val), .busy(busy0),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(aDout0),
    .a_ready(aReady0), .b_re(b_re), .b_addr(b_addr), .b_dout(bDout0), .b_valid(bValid0)
  );

  vram_dp_engine #(
    .DWORD(16), .DWIDTH(12), .CHANNELS(3), .STYLE("distributed"),
    .RD_LAT(2), .A_MODE("WRITE_FIRST"), .CLR_ON_RST(1'b1), .INITFILE("")
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .clr_val(clr_val), .busy(busy1),
    .a_en(a_en), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_dout(aDout1),
    .a_ready(aReady1), .b_re(b_re), .b_addr(b_addr), .b_dout(bDout1), .b_valid(bValid1)
  );

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic checkBit(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic failEvent(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: event missing or unexpected at cycle %0d", name, cycle);
  endtask

  task automatic pushA(input string tag, input logic [11:0] expRf, input logic [11:0] expWf);
    aQ0.push_back('{data: expRf, due: cycle + 1, tag: tag});
    aQ1.push_back('{data: expWf, due: cycle + 2, tag: tag});
  endtask

  task automatic pushB(input string tag, input logic [11:0] exp);
    bQ0.push_back('{data: exp, due: cycle + 1, tag: tag});
    bQ1.push_back('{data: exp, due: cycle + 2, tag: tag});
  endtask

  task automatic applyStimulus(input vec_t v);
    a_en   = v.aEn;
    a_we   = v.we;
    a_addr = v.aAddr;
    a_din  = v.din;
    b_re   = v.bRe;
    b_addr = v.bAddr;
    if (v.aEn) pushA(v.name, v.expRf, v.expWf);
    if (v.bRe) pushB(v.name, v.expB);
    @(negedge clk);
  endtask

  task automatic countBusy(output int n);
    n = 0;
    while (busy0 && n < 64) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while ((aQ0.size() + aQ1.size() + bQ0.size() + bQ1.size()) > 0 && guard < 8) begin
      @(negedge clk);
      guard++;
    end
    if ((aQ0.size() + aQ1.size() + bQ0.size() + bQ1.size()) > 0) begin
      failEvent("scoreboard drain timeout");
      aQ0.delete(); aQ1.delete(); bQ0.delete(); bQ1.delete();
    end
  endtask

  task automatic readAllB(input string tag, input logic [11:0] exp);
    for (int k = 0; k < 16; k++) begin
      b_re   = 1'b1;
      b_addr = 5'(k);
      pushB(tag, exp);
      @(negedge clk);
    end
    b_re = 1'b0;
    drain();
  endtask

  // Scoreboard: compare due port-A words and every completing port-B read against the queues.
  always @(negedge clk) begin : monitor
    sb_t it;
    if (rst_n) begin
      while (aQ0.size() > 0 && aQ0[0].due <= cycle) begin
        it = aQ0.pop_front();
        checkOutput({it.tag, " a_dout0"}, aDout0, it.data);
      end
      while (aQ1.size() > 0 && aQ1[0].due <= cycle) begin
        it = aQ1.pop_front();
        checkOutput({it.tag, " a_dout1"}, aDout1, it.data);
      end
      if (bValid0) begin
        if (bQ0.size() == 0) failEvent("b_valid0 unexpected");
        else begin
          it = bQ0.pop_front();
          checkOutput({it.tag, " b_dout0"}, bDout0, it.data);
          checkInt({it.tag, " b_valid0 cycle"}, cycle, it.due);
        end
      end else if (bQ0.size() > 0 && bQ0[0].due <= cycle) begin
        it = bQ0.pop_front();
        failEvent({it.tag, " b_valid0 missing"});
      end
      if (bValid1) begin
        if (bQ1.size() == 0) failEvent("b_valid1 unexpected");
        else begin
          it = bQ1.pop_front();
          checkOutput({it.tag, " b_dout1"}, bDout1, it.data);
          checkInt({it.tag, " b_valid1 cycle"}, cycle, it.due);
        end
      end else if (bQ1.size() > 0 && bQ1[0].due <= cycle) begin
        it = bQ1.pop_front();
        failEvent({it.tag, " b_valid1 missing"});
      end
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Main stimulus: reset clear, vector table, request clear with drops, aborted clear.
  initial begin
    int n;
    vecs[0]  = '{"mask_wr",  1'b1, 3'b010, 5'd5,  12'h123, 12'hABC, 12'hA2C, 1'b0, 5'd0,  12'h000};
    vecs[1]  = '{"mask_rd",  1'b1, 3'b000, 5'd5,  12'h000, 12'hA2C, 12'hA2C, 1'b1, 5'd5,  12'hA2C};
    vecs[2]  = '{"rdw_wr",   1'b1, 3'b111, 5'd5,  12'h777, 12'hA2C, 12'h777, 1'b1, 5'd5,  12'hA2C};
    vecs[3]  = '{"rdw_rd",   1'b1, 3'b000, 5'd5,  12'h000, 12'h777, 12'h777, 1'b1, 5'd5,  12'h777};
    vecs[4]  = '{"coll_wr",  1'b1, 3'b111, 5'd3,  12'h0F0, 12'hABC, 12'h0F0, 1'b1, 5'd3,  12'hABC};
    vecs[5]  = '{"coll_rd",  1'b0, 3'b000, 5'd0,  12'h000, 12'h000, 12'h000, 1'b1, 5'd3,  12'h0F0};
    vecs[6]  = '{"oor_wr",   1'b1, 3'b111, 5'd16, 12'h555, 12'h000, 12'h000, 1'b1, 5'd16, 12'h000};
    vecs[7]  = '{"oor_chk0", 1'b1, 3'b000, 5'd16, 12'h000, 12'h000, 12'h000, 1'b1, 5'd0,  12'hABC};
    vecs[8]  = '{"lane_wr",  1'b1, 3'b101, 5'd7,  12'hFFF, 12'hABC, 12'hFBF, 1'b1, 5'd7,  12'hABC};
    vecs[9]  = '{"lane_rd",  1'b1, 3'b000, 5'd7,  12'h000, 12'hFBF, 12'hFBF, 1'b1, 5'd7,  12'hFBF};
    vecs[10] = '{"oor_max",  1'b1, 3'b000, 5'd0,  12'h000, 12'hABC, 12'hABC, 1'b1, 5'd31, 12'h000};
    vecs[11] = '{"wr_15",    1'b1, 3'b111, 5'd15, 12'h246, 12'hABC, 12'h246, 1'b1, 5'd15, 12'hABC};
    vecs[12] = '{"rd_15",    1'b0, 3'b000, 5'd0,  12'h000, 12'h000, 12'h000, 1'b1, 5'd15, 12'h246};

    clr_val = 12'hABC;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset a_dout0", aDout0, 12'h000);
    checkOutput("reset a_dout1", aDout1, 12'h000);
    checkOutput("reset b_dout0", bDout0, 12'h000);
    checkOutput("reset b_dout1", bDout1, 12'h000);
    checkBit("reset b_valid0", bValid0, 1'b0);
    checkBit("reset b_valid1", bValid1, 1'b0);
    checkBit("reset busy0", busy0, 1'b1);
    checkBit("reset a_ready1", aReady1, 1'b0);

    rst_n = 1'b1;
    countBusy(n);
    checkInt("busy length after reset", n, 16);
    checkBit("busy1 idle after reset clear", busy1, 1'b0);
    checkBit("a_ready0 after reset clear", aReady0, 1'b1);
    readAllB("rst_clear", 12'hABC);

    for (int v = 0; v < 13; v++) begin
      applyStimulus(vecs[v]);
    end
    a_en = 1'b0;
    b_re = 1'b0;
    drain();
    repeat (3) @(negedge clk);
    checkOutput("a_dout0 hold", aDout0, 12'hABC);
    checkOutput("a_dout1 hold", aDout1, 12'h246);

    clr_val = 12'h5A5;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    clr_val = 12'h000;
    fork
      countBusy(n);
      begin
        checkBit("a_ready0 while busy", aReady0, 1'b0);
        checkBit("a_ready1 while busy", aReady1, 1'b0);
        b_re   = 1'b1;
        b_addr = 5'd15;
        pushB("scan_uncleared", 12'h246);
        @(negedge clk);
        b_addr = 5'd0;
        pushB("scan_cleared", 12'h5A5);
        @(negedge clk);
        b_re    = 1'b0;
        clr_req = 1'b1;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (4) @(negedge clk);
        a_en   = 1'b1;
        a_we   = 3'b111;
        a_addr = 5'd0;
        a_din  = 12'h111;
        @(negedge clk);
        a_en = 1'b0;
      end
    join
    checkInt("busy length with clr_req while busy", n, 16);
    checkOutput("a_dout0 hold over clear", aDout0, 12'hABC);
    checkOutput("a_dout1 hold over clear", aDout1, 12'h246);
    readAllB("req_clear", 12'h5A5);

    clr_val = 12'h3C3;
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (6) @(negedge clk);
    b_re   = 1'b1;
    b_addr = 5'd4;
    @(posedge clk);
    #1;
    checkBit("pre-abort b_valid0", bValid0, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    checkBit("abort b_valid0", bValid0, 1'b0);
    checkBit("abort b_valid1", bValid1, 1'b0);
    checkBit("abort busy0", busy0, 1'b1);
    checkOutput("abort a_dout0", aDout0, 12'h000);
    checkOutput("abort b_dout0", bDout0, 12'h000);
    b_re = 1'b0;
    aQ0.delete(); aQ1.delete(); bQ0.delete(); bQ1.delete();
    @(negedge clk);
    clr_val = 12'hD0D;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    countBusy(n);
    checkInt("busy length after abort", n, 16);
    readAllB("abort_restart", 12'hD0D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
